// File: rtl/interval_timer_seq_pkg.sv
// Shared types and register map for the interval timer sequencer.
package interval_timer_seq_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD_H = 3'd3;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    localparam logic [DATA_W-1:0] CTRL_STOP_VAL  = DATA_W'(1 << CTRL_STOP);
    localparam logic [DATA_W-1:0] CTRL_START_VAL = DATA_W'((1 << CTRL_START) | (1 << CTRL_ITO));

    typedef enum logic [3:0] {
        ST_INIT_STOP,
        ST_INIT_CLR,
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT,
        ST_CANCEL_STOP,
        ST_WR_CLR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
    } avm_wr_t;

    function automatic avm_wr_t avm_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        avm_wr_t w;
        w.address   = a;
        w.writedata = d;
        return w;
    endfunction

endpackage

// File: rtl/interval_timer_seq_rr_arb.sv
// Round-robin grant over NUM_REQ level requests; pointer advances past the winner on accept.
module interval_timer_seq_rr_arb #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       accept,
    output logic                       gnt_valid_c,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_c
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;

    // Scan from highest offset down so the closest request to ptr wins.
    always_comb begin
        int j;
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % int'(NUM_REQ);
            if (req[j]) begin
                gnt_valid_c = 1'b1;
                gnt_idx_c   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept && gnt_valid_c) begin
            ptr <= (32'(gnt_idx_c) == NUM_REQ - 1) ? '0 : gnt_idx_c + IDX_W'(1);
        end
    end

endmodule

// File: rtl/interval_timer_sequencer.sv
// Shares one Avalon-MM interval timer among NUM_REQ requesters (one-shot per grant).
// Optional watchdog abort enabled by defining TIMER_SEQ_WATCHDOG_EN.
module interval_timer_sequencer
    import interval_timer_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PERIOD_W  = 32,
    parameter int unsigned WD_MARGIN = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*PERIOD_W-1:0] req_period,
    output logic [NUM_REQ-1:0]          done,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    output logic                        wd_error,
    output logic [2:0]                  avm_address,
    output logic                        avm_chipselect,
    output logic                        avm_write_n,
    output logic [15:0]                 avm_writedata,
    input  logic                        timer_irq
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t              state;
    avm_wr_t             wr_q;
    logic                cancelled;
    logic [PERIOD_W-1:0] period_q;

    logic                gnt_valid_c;
    logic [IDX_W-1:0]    gnt_idx_c;
    logic [PERIOD_W-1:0] sel_period_c;
    logic [PERIOD_W-1:0] eff_period_c;
    logic [PERIOD_W-1:0] load_src_c;
    logic [31:0]         load_c;
    logic                wd_trip_c;

    assign avm_address   = wr_q.address;
    assign avm_writedata = wr_q.writedata;

    interval_timer_seq_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .accept      (state == ST_IDLE),
        .gnt_valid_c (gnt_valid_c),
        .gnt_idx_c   (gnt_idx_c)
    );

    // Period 0 behaves as 1; the low half is taken from the live request at grant time.
    always_comb begin
        sel_period_c = req_period[32'(gnt_idx_c) * PERIOD_W +: PERIOD_W];
        eff_period_c = (sel_period_c == '0) ? PERIOD_W'(1) : sel_period_c;
        load_src_c   = (state == ST_IDLE) ? eff_period_c : period_q;
        load_c       = 32'(load_src_c - PERIOD_W'(1));
    end

`ifdef TIMER_SEQ_WATCHDOG_EN
    localparam int unsigned CNT_W = PERIOD_W + 1;
    localparam int unsigned CMP_W = PERIOD_W + 2;

    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == ST_WR_CTRL) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    assign wd_trip_c = (state == ST_WAIT) &&
                       (CMP_W'(wd_cnt) > (CMP_W'(period_q) + CMP_W'(WD_MARGIN)));
`else
    assign wd_trip_c = 1'b0;
`endif

    // Each write is registered on entry to the state that owns it, so it is on the bus for that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_INIT_STOP;
            wr_q           <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            done           <= '0;
            owner          <= '0;
            busy           <= 1'b0;
            wd_error       <= 1'b0;
            cancelled      <= 1'b0;
            period_q       <= '0;
        end else begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            done           <= '0;
            case (state)
                ST_INIT_STOP: begin
                    {avm_chipselect, avm_write_n} <= 2'b10;
                    wr_q  <= avm_wr(ADDR_CONTROL, CTRL_STOP_VAL);
                    state <= ST_INIT_CLR;
                end
                ST_INIT_CLR: begin
                    {avm_chipselect, avm_write_n} <= 2'b10;
                    wr_q  <= avm_wr(ADDR_STATUS, 16'h0000);
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (gnt_valid_c) begin
                        {avm_chipselect, avm_write_n} <= 2'b10;
                        wr_q      <= avm_wr(ADDR_PERIOD_L, load_c[15:0]);
                        owner     <= gnt_idx_c;
                        period_q  <= eff_period_c;
                        busy      <= 1'b1;
                        cancelled <= 1'b0;
                        state     <= ST_WR_PL;
                    end
                end
                ST_WR_PL: begin
                    {avm_chipselect, avm_write_n} <= 2'b10;
                    wr_q  <= avm_wr(ADDR_PERIOD_H, load_c[31:16]);
                    state <= ST_WR_PH;
                end
                ST_WR_PH: begin
                    {avm_chipselect, avm_write_n} <= 2'b10;
                    wr_q  <= avm_wr(ADDR_CONTROL, CTRL_START_VAL);
                    state <= ST_WR_CTRL;
                end
                ST_WR_CTRL: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // irq takes priority over a simultaneous cancel or watchdog trip.
                    if (timer_irq) begin
                        {avm_chipselect, avm_write_n} <= 2'b10;
                        wr_q  <= avm_wr(ADDR_STATUS, 16'h0000);
                        state <= ST_WR_CLR;
                    end else if (!req[owner] || wd_trip_c) begin
                        {avm_chipselect, avm_write_n} <= 2'b10;
                        wr_q      <= avm_wr(ADDR_CONTROL, CTRL_STOP_VAL);
                        cancelled <= 1'b1;
                        if (wd_trip_c) begin
                            wd_error <= 1'b1;
                        end
                        state <= ST_CANCEL_STOP;
                    end
                end
                ST_CANCEL_STOP: begin
                    {avm_chipselect, avm_write_n} <= 2'b10;
                    wr_q  <= avm_wr(ADDR_STATUS, 16'h0000);
                    state <= ST_WR_CLR;
                end
                ST_WR_CLR: begin
                    if (cancelled) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        done  <= NUM_REQ'(1) << owner;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interval_timer_sequencer.sv
// Directed bench: sequencer paired with a behavioural interval timer; writes and done pulses are scoreboarded.
module tb_interval_timer_sequencer;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned PERIOD_W = 32;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [NUM_REQ-1:0]          req = '0;
    logic [NUM_REQ*PERIOD_W-1:0] req_period = '0;
    logic [NUM_REQ-1:0]          done;
    logic [1:0]                  owner;
    logic                        busy;
    logic                        wd_error;
    logic [2:0]                  avm_address;
    logic                        avm_chipselect;
    logic                        avm_write_n;
    logic [15:0]                 avm_writedata;
    logic                        timer_irq;

    always #5 clk = ~clk;

    interval_timer_sequencer #(.NUM_REQ(NUM_REQ), .PERIOD_W(PERIOD_W), .WD_MARGIN(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_period     (req_period),
        .done           (done),
        .owner          (owner),
        .busy           (busy),
        .wd_error       (wd_error),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .timer_irq      (timer_irq)
    );

    // Behavioural timer: 0 status(TO), 1 control(ITO/START/STOP), 2/3 period halves, one-shot countdown.
    logic [15:0] t_pl = '0;
    logic [15:0] t_ph = '0;
    logic [31:0] t_cnt = '0;
    logic        t_run = 1'b0;
    logic        t_to = 1'b0;
    logic        t_ito = 1'b0;
    logic        suppress = 1'b0;

    assign timer_irq = t_to & t_ito & ~suppress;

    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n) begin
            case (avm_address)
                3'd0: t_to <= 1'b0;
                3'd1: begin
                    t_ito <= avm_writedata[0];
                    if (avm_writedata[3]) t_run <= 1'b0;
                    if (avm_writedata[2]) begin
                        t_run <= 1'b1;
                        t_cnt <= {t_ph, t_pl};
                    end
                end
                3'd2: t_pl <= avm_writedata;
                3'd3: t_ph <= avm_writedata;
                default: ;
            endcase
        end else if (t_run) begin
            if (t_cnt == 0) begin
                t_to  <= 1'b1;
                t_run <= 1'b0;
            end else begin
                t_cnt <= t_cnt - 1;
            end
        end
    end

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int done_seen = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int prev_wr_cyc = 0;
    int last_wr_cyc = 0;
    logic [18:0] exp_wr[$];
    int          exp_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every bus write and done pulse is matched against the expected queues.
    always @(negedge clk) begin
        logic [18:0] e;
        if (avm_chipselect && !avm_write_n) begin
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            if (avm_address == 3'd1 && avm_writedata == 16'h0005) start_cyc = cyc;
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", {13'd0, avm_address, avm_writedata}, 32'hFFFF_FFFF);
            end else begin
                e = exp_wr.pop_front();
                check("wr", {13'd0, avm_address, avm_writedata}, {13'd0, e});
            end
        end
        if (done != '0) begin
            done_seen++;
            done_cyc = cyc;
            if (exp_done.size() == 0) check("done_unexpected", 32'(done), 32'd0);
            else check("done", 32'(done), 32'd1 << exp_done.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic push_init();
        push_wr(3'd1, 16'h0008);
        push_wr(3'd0, 16'h0000);
    endtask

    task automatic push_op(input logic [31:0] load, input bit cancel);
        push_wr(3'd2, load[15:0]);
        push_wr(3'd3, load[31:16]);
        push_wr(3'd1, 16'h0005);
        if (cancel) push_wr(3'd1, 16'h0008);
        push_wr(3'd0, 16'h0000);
    endtask

    task automatic set_period(input int i, input logic [31:0] p);
        req_period[i*PERIOD_W +: PERIOD_W] = p;
    endtask

    task automatic wait_dones(input int target, input int limit);
        for (int i = 0; i < limit && done_seen < target; i++) begin
            @(negedge clk);
            #1;
        end
        check("done_count", 32'(done_seen), 32'(target));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_owner"}, 32'(owner), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_wd_error"}, 32'(wd_error), 32'd0);
        check({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
        check({tag, "_write_n"}, 32'(avm_write_n), 32'd1);
        check({tag, "_addr"}, 32'(avm_address), 32'd0);
        check({tag, "_data"}, 32'(avm_writedata), 32'd0);
    endtask

    initial begin
        int base;
        int lat;

        // Reset values, then INIT writes on consecutive cycles.
        tick(3);
        @(negedge clk);
        check_reset_vals("rst");
        push_init();
        @(posedge clk); #1;
        reset = 1'b0;
        tick(6);
        check("init_consecutive", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);
        check("init_drained", 32'(exp_wr.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Single request, period 100; later period change must be ignored.
        set_period(1, 32'd100);
        push_op(32'd99, 1'b0);
        exp_done.push_back(1);
        req[1] = 1'b1;
        for (int i = 0; i < 20 && !busy; i++) tick(1);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_owner", 32'(owner), 32'd1);
        set_period(1, 32'd7);
        base = done_seen;
        wait_dones(base + 1, 200);
        @(posedge clk); #1;
        req[1] = 1'b0;
        lat = done_cyc - start_cyc;
        check("t2_start_to_done_in_97_103", 32'(lat >= 97 && lat <= 103), 32'd1);
        tick(3);
        check("t2_busy_after", 32'(busy), 32'd0);

        // Fresh pointer, all four held: done order 0,1,2,3,0.
        reset = 1'b1;
        tick(2);
        push_init();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_period(i, 32'd10);
        for (int i = 0; i < 5; i++) begin
            push_op(32'd9, 1'b0);
            exp_done.push_back(i % 4);
        end
        req = 4'b1111;
        base = done_seen;
        wait_dones(base + 5, 400);
        @(posedge clk); #1;
        req = '0;
        tick(5);
        check("t3_drained", 32'(exp_wr.size()), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);

        // Cancel by dropping the request mid-wait, then a normal grant.
        set_period(2, 32'd1000);
        push_op(32'd999, 1'b1);
        req[2] = 1'b1;
        base = done_seen;
        tick(200);
        req[2] = 1'b0;
        tick(10);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_no_done", 32'(done_seen), 32'(base));
        check("t4_drained", 32'(exp_wr.size()), 32'd0);
        set_period(0, 32'd5);
        push_op(32'd4, 1'b0);
        exp_done.push_back(0);
        req[0] = 1'b1;
        wait_dones(base + 1, 100);
        @(posedge clk); #1;
        req[0] = 1'b0;

        // Boundary periods: 0 loads 0; 0x1_0000 loads 0xFFFF.
        set_period(3, 32'd0);
        push_op(32'd0, 1'b0);
        exp_done.push_back(3);
        req[3] = 1'b1;
        base = done_seen;
        wait_dones(base + 1, 100);
        @(posedge clk); #1;
        req[3] = 1'b0;
        set_period(1, 32'h0001_0000);
        push_op(32'h0000_FFFF, 1'b1);
        req[1] = 1'b1;
        tick(30);
        req[1] = 1'b0;
        tick(8);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_drained", 32'(exp_wr.size()), 32'd0);

        // irq suppressed, period 50.
        suppress = 1'b1;
        set_period(0, 32'd50);
        push_op(32'd49, 1'b1);
        base = done_seen;
        req[0] = 1'b1;
`ifdef TIMER_SEQ_WATCHDOG_EN
        for (int i = 0; i < 150 && !wd_error; i++) tick(1);
        req[0] = 1'b0;
        lat = cyc - start_cyc;
        check("t6_wd_error", 32'(wd_error), 32'd1);
        check("t6_wd_latency_in_60_72", 32'(lat >= 60 && lat <= 72), 32'd1);
`else
        tick(150);
        check("t6_wait_holds", 32'(busy), 32'd1);
        check("t6_wd_error_tied", 32'(wd_error), 32'd0);
        req[0] = 1'b0;
`endif
        tick(6);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_no_done", 32'(done_seen), 32'(base));
        suppress = 1'b0;

        // Reset in the middle of WAIT: reset values, no done, INIT repeats.
        set_period(0, 32'd1000);
        push_wr(3'd2, 16'h03E7);
        push_wr(3'd3, 16'h0000);
        push_wr(3'd1, 16'h0005);
        req[0] = 1'b1;
        tick(20);
        check("t7_busy_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        req[0] = 1'b0;
        tick(1);
        @(negedge clk);
        check_reset_vals("midrst");
        push_init();
        @(posedge clk); #1;
        reset = 1'b0;
        tick(8);
        check("t7_drained", 32'(exp_wr.size()), 32'd0);
        check("t7_no_done", 32'(done_seen), 32'(base));
        check("t7_busy", 32'(busy), 32'd0);
        check("exp_done_drained", 32'(exp_done.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
